input_debouncer: RTL and testbench
==================================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter: STABLE_CYCLES, default 16, number of consecutive synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter: CNT_W, default 16, counter width; SHALL satisfy 2**CNT_W > STABLE_CYCLES.
REQ-003 Port: clk  input  1  single system clock, all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: din  input  1  raw asynchronous input (switch/button), no timing relation to clk.
REQ-006 Port: q  output  1  debounced level, registered.
REQ-007 Port: rise  output  1  one-cycle pulse on accepted 0->1 change, registered.
REQ-008 Port: fall  output  1  one-cycle pulse on accepted 1->0 change, registered.
REQ-009 Port: busy  output  1  high while a candidate change is being qualified (CHK states).

Function
REQ-010 din SHALL pass through a two-flop synchronizer (s1, s2); only s2 (din_sync) feeds the FSM.
REQ-011 FSM states: LOW, RISE_CHK, HIGH, FALL_CHK; one state register plus counter cnt[CNT_W-1:0].
REQ-012 LOW: q=0; din_sync=1 -> RISE_CHK with cnt<=0; else stay.
REQ-013 RISE_CHK: din_sync=0 -> LOW, cnt<=0, no pulse; din_sync=1 and cnt==STABLE_CYCLES-1 -> HIGH, q<=1, rise<=1; else cnt<=cnt+1.
REQ-014 HIGH: q=1; din_sync=0 -> FALL_CHK with cnt<=0; else stay.
REQ-015 FALL_CHK: din_sync=1 -> HIGH, cnt<=0, no pulse; din_sync=0 and cnt==STABLE_CYCLES-1 -> LOW, q<=0, fall<=1; else cnt<=cnt+1.
REQ-016 rise and fall SHALL be high for exactly one clk cycle per accepted change and never simultaneously.
REQ-017 busy SHALL be 1 exactly when state is RISE_CHK or FALL_CHK (registered or decoded from state register; no glitch path from din).
REQ-018 Latency: din held 1 from before edge E0 -> din_sync=1 after E1 -> RISE_CHK after E2 -> q=1 and rise=1 after edge E(STABLE_CYCLES+2); symmetric for falling.
REQ-019 Any single-cycle opposite sample of din_sync during a CHK state SHALL abort qualification; count restarts from 0 on the next candidate.
REQ-020 cnt SHALL never exceed STABLE_CYCLES-1; no wrap-around possible.
REQ-021 q SHALL change only on an accepted transition; aborted qualifications leave q unchanged.

Reset
REQ-022 rst=1 SHALL immediately (asynchronously) force s1=0, s2=0, state=LOW, cnt=0, q=0, rise=0, fall=0, busy=0.
REQ-023 Reset asserted mid-qualification SHALL discard the candidate with no pulse emitted.
REQ-024 After rst deasserts with din=1, the block SHALL qualify normally and emit one rise pulse per REQ-018.

Verification (STABLE_CYCLES=4)
REQ-025 Reset then din=0 for 20 cycles -> q=0, rise=fall=busy=0 throughout.
REQ-026 din 0->1 before E0, held -> busy=1 after E2, q=1 and rise=1 after E6, rise=0 after E7, busy=0 after E6.
REQ-027 From q=1, din pulses low for 2 cycles then returns high -> busy asserts, aborts, q stays 1, fall never asserts.
REQ-028 Bounce: din toggles every cycle for 10 cycles then settles high -> no pulse during bouncing; exactly one rise pulse, 7 cycles after last sampled transition's synchronizer exit per REQ-018.
REQ-029 rst asserted asynchronously between edges while in RISE_CHK (cnt=2) -> q, busy, cnt go 0 before next edge; after release with din=1, one rise pulse at E(STABLE_CYCLES+2) relative to first post-release edge.
REQ-030 Full cycle: accepted rise then din low held -> fall=1 for one cycle exactly 6 edges after din low sampled at E0, q=0 thereafter.

Source files
------------

// File: rtl/input_debouncer.sv
// Switch/button debouncer: two-flop synchronizer followed by a four-state
// qualifier that accepts a level only after STABLE_CYCLES+1 agreeing samples.
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    localparam int unsigned    LAST_IDX = STABLE_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_IDX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // sync_reg[0] is s1 (may go metastable), sync_reg[1] is s2 = din_sync
    logic [1:0]       sync_reg;
    logic             din_sync;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             q_reg;
    logic             rise_reg;
    logic             fall_reg;

    assign din_sync = sync_reg[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            q_reg     <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
                LOW: begin
                    if (din_sync) begin
                        state_reg <= RISE_CHK;
                        cnt_reg   <= '0;
                    end
                end
                RISE_CHK: begin
                    if (!din_sync) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                        q_reg     <= 1'b1;
                        rise_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!din_sync) begin
                        state_reg <= FALL_CHK;
                        cnt_reg   <= '0;
                    end
                end
                FALL_CHK: begin
                    if (din_sync) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                        q_reg     <= 1'b0;
                        fall_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // busy is decoded purely from the state register, so din cannot glitch it
    assign busy = (state_reg == RISE_CHK) || (state_reg == FALL_CHK);
    assign q    = q_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: run-length reference model,
// per-cycle comparison, directed latency/abort/reset cases and random bouncing.
module tb_input_debouncer;

    localparam int unsigned STABLE = 4;

    logic clk;
    logic rst;
    logic din;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;

    input_debouncer #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .q   (q),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: din reaches the qualifier two edges late; the level flips once
    // STABLE+1 consecutive qualifier samples disagree with the accepted level.
    logic m_d1, m_d2, m_q, m_rise, m_fall;
    int   m_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1   <= 1'b0;
            m_d2   <= 1'b0;
            m_q    <= 1'b0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            m_run  <= 0;
        end else begin
            m_d1   <= din;
            m_d2   <= m_d1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_d2 != m_q) begin
                if (m_run == int'(STABLE)) begin
                    m_q    <= m_d2;
                    m_rise <= m_d2;
                    m_fall <= !m_d2;
                    m_run  <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_q", int'(q), int'(m_q));
        chk("model_rise", int'(rise), int'(m_rise));
        chk("model_fall", int'(fall), int'(m_fall));
        chk("model_busy", int'(busy), int'(m_run != 0));
        chk("rise_fall_excl", int'(rise & fall), 0);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_q"}, int'(q), 0);
        chk({name, "_rise"}, int'(rise), 0);
        chk({name, "_fall"}, int'(fall), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int saw_busy;
        int n_rise;
        int n_fall;

        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // Quiet low input
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("quiet");
        end

        // Clean rise: din set before E0
        din = 1'b1;
        tick();                                   // E0
        tick();                                   // E1
        chk("rise_e1_busy", int'(busy), 0);
        tick();                                   // E2
        chk("rise_e2_busy", int'(busy), 1);
        chk("rise_e2_q", int'(q), 0);
        for (int e = 3; e <= 5; e++) begin
            tick();
            chk("rise_wait_q", int'(q), 0);
            chk("rise_wait_rise", int'(rise), 0);
        end
        tick();                                   // E6
        chk("rise_e6_q", int'(q), 1);
        chk("rise_e6_rise", int'(rise), 1);
        chk("rise_e6_busy", int'(busy), 0);
        tick();                                   // E7
        chk("rise_e7_rise", int'(rise), 0);
        chk("rise_e7_q", int'(q), 1);

        // Two-cycle low glitch must abort
        saw_busy = 0;
        n_fall   = 0;
        din = 1'b0;
        tick();
        tick();
        din = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy) saw_busy = 1;
            if (fall) n_fall++;
        end
        chk("glitch_busy_seen", saw_busy, 1);
        chk("glitch_no_fall", n_fall, 0);
        chk("glitch_q_kept", int'(q), 1);

        // Full fall
        din = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            tick();
            chk("fall_wait", int'(fall), 0);
        end
        tick();                                   // E6
        chk("fall_e6_fall", int'(fall), 1);
        chk("fall_e6_q", int'(q), 0);
        tick();
        chk("fall_e7_fall", int'(fall), 0);
        chk("fall_e7_q", int'(q), 0);

        // Bounce then settle high
        n_rise = 0;
        for (int i = 0; i < 10; i++) begin
            din = (i % 2 == 0);
            tick();
            if (rise) n_rise++;
        end
        din = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (rise) n_rise++;
        end
        chk("bounce_no_early_rise", n_rise, 0);
        tick();                                   // T6
        chk("bounce_t6_rise", int'(rise), 1);
        n_rise = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rise) n_rise++;
        end
        chk("bounce_one_rise", n_rise, 1);

        // Back to low, then reset mid rise qualification
        din = 1'b0;
        repeat (10) tick();
        chk("pre_reset_q", int'(q), 0);
        din = 1'b1;
        repeat (5) tick();                        // after E4: cnt is 2
        chk("mid_chk_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1 chk_idle("async_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            tick();
            chk("post_reset_wait", int'(rise), 0);
        end
        tick();                                   // E6 after release
        chk("post_reset_rise", int'(rise), 1);
        chk("post_reset_q", int'(q), 1);

        // Randomised bouncing with occasional asynchronous resets
        for (int seg = 0; seg < 300; seg++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12))
                                              : int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
                din = v;
                tick();
            end
            if ($urandom_range(0, 39) == 0) begin
                #3 rst = 1'b1;
                #1 chk_idle("rand_reset");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
